// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
//   Shared types and constants for the runtime-programmable video timing
//   generator.
//
//   Contents:
//     VT_W           - width of every counter and timing field
//     DEF_*_1080P    - default 1080p-style timing used as shadow reset values
//     timing_axis_t  - {period, sync, start, len} description of one axis.
//                      Period sits in the MSBs, which matches the layout of
//                      the cfg_h / cfg_v ports.
//     clamp_axis     - forces a loaded period up to a legal minimum
// -----------------------------------------------------------------------------
package video_timing_pkg;

    localparam int VT_W = 12;

    localparam int DEF_HPERIOD_1080P = 1100;
    localparam int DEF_HSYNC_1080P   = 22;
    localparam int DEF_HSTART_1080P  = 96;
    localparam int DEF_HWIDTH_1080P  = 960;
    localparam int DEF_VPERIOD_1080P = 1125;
    localparam int DEF_VSYNC_1080P   = 5;
    localparam int DEF_VSTART_1080P  = 30;
    localparam int DEF_VLINES_1080P  = 1080;

    typedef struct packed {
        logic [VT_W-1:0] period;
        logic [VT_W-1:0] sync;
        logic [VT_W-1:0] start;
        logic [VT_W-1:0] len;
    } timing_axis_t;

    // The counters need period-1 to be a reachable value, so a period
    // below the minimum is raised to it. The other fields pass unchanged.
    function automatic timing_axis_t clamp_axis(input timing_axis_t raw,
                                                input logic [VT_W-1:0] min_period);
        timing_axis_t t;
        t = raw;
        if (raw.period < min_period) begin
            t.period = min_period;
        end
        return t;
    endfunction

endpackage

// File: rtl/video_timing_axis.sv
// -----------------------------------------------------------------------------
// video_timing_axis
//   One timing axis: a wrapping position counter plus sync and active-window
//   decode. The generator uses one instance for H (always advancing) and one
//   for V (advancing on the H wrap).
//
//   Ports:
//     clk, rstn   pixel clock, asynchronous active-low reset
//     en          low forces the counter to 0
//     adv         advance the counter this cycle
//     period      counter runs 0..period-1
//     sync        sync_act while cnt < sync
//     start, len  win_act while start <= cnt < start+len
//     cnt         current position
//     wrap        cnt is at period-1 (last position of the axis)
//     sync_act    sync region decode
//     win_act     active window decode
// -----------------------------------------------------------------------------
module video_timing_axis #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             adv,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] sync,
    input  logic [CNT_W-1:0] start,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             sync_act,
    output logic             win_act
);

    logic [CNT_W:0] win_end;

    assign wrap     = (cnt == period - CNT_W'(1));
    assign sync_act = (cnt < sync);

    // The window end is one bit wider so start+len never overflows. Since
    // cnt never reaches period, a window that extends past the period is
    // cut off there automatically.
    assign win_end  = {1'b0, start} + {1'b0, len};
    assign win_act  = (cnt >= start) && ({1'b0, cnt} < win_end);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Runtime-programmable video sync generator. It produces hsync, vsync and
//   de, a DMA line-prefetch pulse, the pixel/line position and a frame-start
//   strobe. Timing is written through cfg_* into shadow registers that only
//   take effect at a frame boundary (or immediately while en is low).
//
//   Ports:
//     clk, rstn        pixel clock, asynchronous active-low reset
//     en               run enable; low idles the generator at x=0, y=0
//     cfg_h, cfg_v     {period, sync, start, width/lines}, period in MSBs
//     cfg_hs_pol/vs_pol  sync active level (0 = active-low)
//     cfg_update       request a shadow load at the next frame boundary
//     cfg_ack          one-cycle pulse when the shadow load happens
//     hsync, vsync, de registered timing outputs
//     dma_req          one-cycle pulse requesting the next line fetch
//     frame_start      one-cycle pulse aligned with x_pos=0, y_pos=0
//     x_pos, y_pos     position aligned with de
//     frame_cnt        (only with VIDEO_TIMING_GEN_FRAME_CNT_EN) frame counter
//
//   Build option:
//     VIDEO_TIMING_GEN_FRAME_CNT_EN - adds the 16-bit frame_cnt output.
// -----------------------------------------------------------------------------
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CNT_W          = VT_W,
    parameter int DMA_LEAD_LINES = 1,
    parameter int DEF_HPERIOD    = DEF_HPERIOD_1080P,
    parameter int DEF_HSYNC      = DEF_HSYNC_1080P,
    parameter int DEF_HSTART     = DEF_HSTART_1080P,
    parameter int DEF_HWIDTH     = DEF_HWIDTH_1080P,
    parameter int DEF_VPERIOD    = DEF_VPERIOD_1080P,
    parameter int DEF_VSYNC      = DEF_VSYNC_1080P,
    parameter int DEF_VSTART     = DEF_VSTART_1080P,
    parameter int DEF_VLINES     = DEF_VLINES_1080P
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [4*CNT_W-1:0] cfg_h,
    input  logic [4*CNT_W-1:0] cfg_v,
    input  logic               cfg_hs_pol,
    input  logic               cfg_vs_pol,
    input  logic               cfg_update,
    output logic               cfg_ack,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               dma_req,
    output logic               frame_start,
    output logic [CNT_W-1:0]   x_pos,
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    output logic [CNT_W-1:0]   y_pos,
    output logic [15:0]        frame_cnt
`else
    output logic [CNT_W-1:0]   y_pos
`endif
);

    localparam logic [CNT_W:0] LEAD_EXT = (CNT_W+1)'(DMA_LEAD_LINES);

    timing_axis_t     h_cfg_q;
    timing_axis_t     v_cfg_q;
    logic             hs_pol_q;
    logic             vs_pol_q;
    logic             cfg_pending;

    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_act;
    logic             vs_act;
    logic             h_win;
    logic             v_win;

    logic             lpf;
    logic             load;

    logic [CNT_W:0]   h_end;
    logic [CNT_W-1:0] dma_x;
    logic [CNT_W:0]   lead_y;
    logic             lead_win;
    logic             dma_hit;

    video_timing_axis #(.CNT_W(CNT_W)) u_h_axis (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .adv      (1'b1),
        .period   (h_cfg_q.period),
        .sync     (h_cfg_q.sync),
        .start    (h_cfg_q.start),
        .len      (h_cfg_q.len),
        .cnt      (x),
        .wrap     (h_wrap),
        .sync_act (hs_act),
        .win_act  (h_win)
    );

    video_timing_axis #(.CNT_W(CNT_W)) u_v_axis (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .adv      (h_wrap),
        .period   (v_cfg_q.period),
        .sync     (v_cfg_q.sync),
        .start    (v_cfg_q.start),
        .len      (v_cfg_q.len),
        .cnt      (y),
        .wrap     (v_wrap),
        .sync_act (vs_act),
        .win_act  (v_win)
    );

    // A request seen in the last-pixel cycle itself still counts, so
    // cfg_update is folded in alongside the pending flag. While idle the
    // counters are parked at 0, so loading immediately is always safe.
    assign lpf  = en && h_wrap && v_wrap;
    assign load = (cfg_pending || cfg_update) && (lpf || !en);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cfg_q     <= '{period: CNT_W'(DEF_HPERIOD), sync: CNT_W'(DEF_HSYNC),
                             start: CNT_W'(DEF_HSTART), len: CNT_W'(DEF_HWIDTH)};
            v_cfg_q     <= '{period: CNT_W'(DEF_VPERIOD), sync: CNT_W'(DEF_VSYNC),
                             start: CNT_W'(DEF_VSTART), len: CNT_W'(DEF_VLINES)};
            hs_pol_q    <= 1'b0;
            vs_pol_q    <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_ack     <= 1'b0;
        end else begin
            cfg_ack <= load;
            if (load) begin
                h_cfg_q     <= clamp_axis(cfg_h, VT_W'(2));
                v_cfg_q     <= clamp_axis(cfg_v, VT_W'(1));
                hs_pol_q    <= cfg_hs_pol;
                vs_pol_q    <= cfg_vs_pol;
                cfg_pending <= 1'b0;
            end else if (cfg_update) begin
                cfg_pending <= 1'b1;
            end
        end
    end

    // The fetch point is the first pixel after the active window, pulled
    // back to the last pixel of the line when the window runs past it.
    assign h_end = {1'b0, h_cfg_q.start} + {1'b0, h_cfg_q.len};

    always_comb begin
        dma_x = h_end[CNT_W-1:0];
        if (h_end >= {1'b0, h_cfg_q.period}) begin
            dma_x = h_cfg_q.period - CNT_W'(1);
        end
    end

    // Line being prefetched, modulo the frame height. The lead is at most 3
    // and y < period, so a few conditional subtractions replace a divider
    // even for a one-line frame.
    always_comb begin
        lead_y = {1'b0, y} + LEAD_EXT;
        for (int i = 0; i < 4; i++) begin
            if (lead_y >= {1'b0, v_cfg_q.period}) begin
                lead_y = lead_y - {1'b0, v_cfg_q.period};
            end
        end
    end

    assign lead_win = (lead_y >= {1'b0, v_cfg_q.start}) &&
                      (lead_y < ({1'b0, v_cfg_q.start} + {1'b0, v_cfg_q.len}));
    assign dma_hit  = (x == dma_x) && lead_win;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            dma_req     <= 1'b0;
            frame_start <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
        end else if (!en) begin
            hsync       <= ~hs_pol_q;
            vsync       <= ~vs_pol_q;
            de          <= 1'b0;
            dma_req     <= 1'b0;
            frame_start <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
        end else begin
            hsync       <= ~(hs_act ^ hs_pol_q);
            vsync       <= ~(vs_act ^ vs_pol_q);
            de          <= h_win && v_win;
            dma_req     <= dma_hit;
            frame_start <= (x == '0) && (y == '0);
            x_pos       <= x;
            y_pos       <= y;
        end
    end

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= 16'd0;
        end else if (!en) begin
            frame_cnt <= 16'd0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//   Directed self-checking bench for video_timing_gen: default timing after
//   reset, a small programmed frame, DMA lead, frame-boundary config updates,
//   sync polarity, en handling, window truncation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [47:0] cfg_h;
    logic [47:0] cfg_v;
    logic        cfg_hs_pol;
    logic        cfg_vs_pol;
    logic        cfg_update;
    logic        cfg_ack;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        dma_req;
    logic        frame_start;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checkCount = 0;
    int failCount  = 0;

    video_timing_gen dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .cfg_h       (cfg_h),
        .cfg_v       (cfg_v),
        .cfg_hs_pol  (cfg_hs_pol),
        .cfg_vs_pol  (cfg_vs_pol),
        .cfg_update  (cfg_update),
        .cfg_ack     (cfg_ack),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .dma_req     (dma_req),
        .frame_start (frame_start),
        .x_pos       (x_pos),
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .y_pos       (y_pos)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] pack4(input int a, input int b, input int c, input int d);
        return {12'(a), 12'(b), 12'(c), 12'(d)};
    endfunction

    // Drives a configuration and a one-cycle cfg_update pulse; returns on
    // the following falling edge.
    task automatic applyStimulus(input logic [47:0] h, input logic [47:0] v,
                                 input logic hpol, input logic vpol);
        cfg_h      = h;
        cfg_v      = v;
        cfg_hs_pol = hpol;
        cfg_vs_pol = vpol;
        cfg_update = 1'b1;
        @(negedge clk);
        cfg_update = 1'b0;
    endtask

    // Walks 'cycles' output cycles starting at x_pos=0, y_pos=0 of a frame
    // with V = {10,1,2,5}, vsync active-low and a one-line DMA lead, and
    // checks every cycle plus hand-computed per-run totals.
    task automatic checkFrame(input string tag, input int cycles,
                              input int hp, input int hs, input int hst, input int hw,
                              input logic pol,
                              input int expDe, input int expHsAct,
                              input int expDma, input int expFs);
        int deN, hsN, dmaN, fsN;
        int x, y, ly, dx;
        logic eDe, eHs, eVs, eDma, eFs;
        logic [31:0] obs, exp;
        deN = 0; hsN = 0; dmaN = 0; fsN = 0;
        dx = (hst + hw >= hp) ? hp - 1 : hst + hw;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            x    = i % hp;
            y    = (i / hp) % 10;
            ly   = (y + 1) % 10;
            eDe  = (x >= hst) && (x < hst + hw) && (y >= 2) && (y < 7);
            eHs  = (x < hs) ? pol : ~pol;
            eVs  = (y < 1) ? 1'b0 : 1'b1;
            eDma = (x == dx) && (ly >= 2) && (ly < 7);
            eFs  = (x == 0) && (y == 0);
            obs  = {3'b0, x_pos, y_pos, de, hsync, vsync, dma_req, frame_start};
            exp  = {3'b0, 12'(x), 12'(y), eDe, eHs, eVs, eDma, eFs};
            checkOutput({tag, "_cycle"}, obs, exp);
            deN  += int'(de);
            hsN  += int'(hsync == pol);
            dmaN += int'(dma_req);
            fsN  += int'(frame_start);
        end
        checkOutput({tag, "_de_count"},    deN,  expDe);
        checkOutput({tag, "_hsact_count"}, hsN,  expHsAct);
        checkOutput({tag, "_dma_count"},   dmaN, expDma);
        checkOutput({tag, "_fs_count"},    fsN,  expFs);
    endtask

    initial begin
        int firstDe;
        logic found;

        rstn       = 1'b0;
        en         = 1'b1;
        cfg_h      = pack4(16, 2, 4, 8);
        cfg_v      = pack4(10, 1, 2, 5);
        cfg_hs_pol = 1'b0;
        cfg_vs_pol = 1'b0;
        cfg_update = 1'b0;

        // Reset state
        repeat (10) @(negedge clk);
        checkOutput("rst_hsync", hsync, 1);
        checkOutput("rst_vsync", vsync, 1);
        checkOutput("rst_flags", {de, dma_req, frame_start, cfg_ack}, 4'b0000);
        checkOutput("rst_pos", {x_pos, y_pos}, 24'h0);

        // Default 1080p timing: first de after 30*1100+96+1 cycles
        rstn    = 1'b1;
        firstDe = 0;
        for (int k = 1; k <= 40000; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                checkOutput("def_fs_first", frame_start, 1);
                checkOutput("def_hsync_first", hsync, 0);
            end
            if (de) begin
                firstDe = k;
                break;
            end
        end
        checkOutput("def_first_de", firstDe, 33097);
        checkOutput("def_first_de_pos", {x_pos, y_pos}, {12'd96, 12'd30});

        // Drop en mid-line while loading the small frame
        @(negedge clk);
        en = 1'b0;
        applyStimulus(pack4(16, 2, 4, 8), pack4(10, 1, 2, 5), 1'b0, 1'b0);
        checkOutput("enlow_de", de, 0);
        checkOutput("enlow_pos", {x_pos, y_pos}, 24'h0);
        checkOutput("enlow_hsync", hsync, 1);
        checkOutput("enlow_ack", cfg_ack, 1);
        @(negedge clk);
        checkOutput("enlow_ack_clear", cfg_ack, 0);
        checkOutput("enlow_dma", dma_req, 0);
        en = 1'b1;

        // Small frame, two frames
        checkFrame("small", 320, 16, 2, 4, 8, 1'b0, 80, 40, 10, 2);

        // Mid-frame update to H period 20: ack only on the last pixel
        applyStimulus(pack4(20, 2, 4, 8), pack4(10, 1, 2, 5), 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (cfg_ack) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("upd_ack_seen", found, 1);
        checkOutput("upd_ack_pos", {x_pos, y_pos}, {12'd15, 12'd9});
        checkFrame("p20", 200, 20, 2, 4, 8, 1'b0, 40, 20, 5, 1);

        // Update requested in the last-pixel cycle itself
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (x_pos == 12'd18 && y_pos == 12'd9) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("lpf_wait", found, 1);
        applyStimulus(pack4(16, 2, 10, 12), pack4(10, 1, 2, 5), 1'b1, 1'b0);
        checkOutput("lpf_ack", cfg_ack, 1);
        checkOutput("lpf_ack_pos", {x_pos, y_pos}, {12'd19, 12'd9});

        // Truncated window, hsync active-high
        checkFrame("trunc", 160, 16, 2, 10, 12, 1'b1, 30, 20, 5, 1);

        // Asynchronous reset while de is active
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (de) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("arst_wait_de", found, 1);
        rstn = 1'b0;
        #1;
        checkOutput("arst_de", de, 0);
        checkOutput("arst_hsync", hsync, 1);
        checkOutput("arst_pos", {x_pos, y_pos}, 24'h0);
        checkOutput("arst_pulses", {dma_req, frame_start, cfg_ack}, 3'b000);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
